// File: rtl/mouse_master_sm.sv
// PS/2 mouse master sequencer: runs the reset / enable-streaming handshake with the
// mouse, then assembles 3-byte stream packets and pulses an interrupt per packet.
module mouse_master_sm #(
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int STARTUP_CYCLES = 500000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic       INIT_DONE,
  output logic [3:0] STATE_DBG
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(STARTUP_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SU_LAST = SW'(STARTUP_CYCLES - 1);

  typedef enum logic [3:0] {
    S_INIT         = 4'd0,
    S_SEND_FF      = 4'd1,
    S_WAIT_SENT_FF = 4'd2,
    S_WAIT_FA1     = 4'd3,
    S_WAIT_AA      = 4'd4,
    S_WAIT_ID      = 4'd5,
    S_SEND_F4      = 4'd6,
    S_WAIT_SENT_F4 = 4'd7,
    S_WAIT_FA2     = 4'd8,
    S_PKT_B1       = 4'd9,
    S_PKT_B2       = 4'd10,
    S_PKT_B3       = 4'd11,
    S_IRQ          = 4'd12
  } state_t;

  state_t        state_q;
  logic [TW-1:0] timeout_q;
  logic [SW-1:0] startup_q;
  logic          send_byte_q;
  logic [7:0]    byte_to_send_q;
  logic          read_enable_q;
  logic [7:0]    status_q, dx_q, dy_q;
  logic [7:0]    sh_status_q, sh_dx_q;
  logic          irq_q;
  logic          init_done_q;

  logic       rx_ok;
  logic       rx_match;
  logic       timeout_hit;
  logic [7:0] exp_byte;

  // Byte each init response state is waiting for.
  always_comb begin
    exp_byte = 8'hFA;
    case (state_q)
      S_WAIT_AA: exp_byte = 8'hAA;
      S_WAIT_ID: exp_byte = 8'h00;
      default:   exp_byte = 8'hFA;
    endcase
  end

  assign rx_ok       = BYTE_READY && (BYTE_ERROR_CODE == 2'd0);
  assign rx_match    = rx_ok && (BYTE_READ == exp_byte);
  assign timeout_hit = (timeout_q == TO_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= S_INIT;
      timeout_q      <= '0;
      startup_q      <= '0;
      send_byte_q    <= 1'b0;
      byte_to_send_q <= 8'h00;
      read_enable_q  <= 1'b0;
      status_q       <= 8'h00;
      dx_q           <= 8'h00;
      dy_q           <= 8'h00;
      sh_status_q    <= 8'h00;
      sh_dx_q        <= 8'h00;
      irq_q          <= 1'b0;
      init_done_q    <= 1'b0;
    end else begin
      send_byte_q <= 1'b0;
      irq_q       <= 1'b0;
      startup_q   <= '0;
      // Every transition below overrides this with a clear.
      timeout_q   <= timeout_q + 1'b1;
      case (state_q)
        S_INIT: begin
          timeout_q <= '0;
          if (startup_q == SU_LAST) begin
            state_q        <= S_SEND_FF;
            send_byte_q    <= 1'b1;
            byte_to_send_q <= 8'hFF;
          end else begin
            startup_q <= startup_q + 1'b1;
          end
        end
        S_SEND_FF: begin
          state_q   <= S_WAIT_SENT_FF;
          timeout_q <= '0;
        end
        S_SEND_F4: begin
          state_q   <= S_WAIT_SENT_F4;
          timeout_q <= '0;
        end
        S_WAIT_SENT_FF, S_WAIT_SENT_F4: begin
          if (BYTE_SENT) begin
            state_q       <= (state_q == S_WAIT_SENT_FF) ? S_WAIT_FA1 : S_WAIT_FA2;
            read_enable_q <= 1'b1;
            timeout_q     <= '0;
          end else if (timeout_hit) begin
            state_q       <= S_INIT;
            read_enable_q <= 1'b0;
            init_done_q   <= 1'b0;
            timeout_q     <= '0;
          end
        end
        S_WAIT_FA1, S_WAIT_AA, S_WAIT_ID, S_WAIT_FA2: begin
          if (rx_match) begin
            timeout_q <= '0;
            case (state_q)
              S_WAIT_FA1: state_q <= S_WAIT_AA;
              S_WAIT_AA:  state_q <= S_WAIT_ID;
              S_WAIT_ID: begin
                state_q        <= S_SEND_F4;
                send_byte_q    <= 1'b1;
                byte_to_send_q <= 8'hF4;
                read_enable_q  <= 1'b0;
              end
              default: begin
                state_q     <= S_PKT_B1;
                init_done_q <= 1'b1;
              end
            endcase
          end else if (BYTE_READY || timeout_hit) begin
            state_q       <= S_INIT;
            read_enable_q <= 1'b0;
            init_done_q   <= 1'b0;
            timeout_q     <= '0;
          end
        end
        S_PKT_B1: begin
          // No timeout here; bytes without the always-one bit are dropped to resync.
          timeout_q <= '0;
          if (rx_ok && BYTE_READ[3]) begin
            sh_status_q <= BYTE_READ;
            state_q     <= S_PKT_B2;
          end
        end
        S_PKT_B2: begin
          if (rx_ok) begin
            sh_dx_q   <= BYTE_READ;
            state_q   <= S_PKT_B3;
            timeout_q <= '0;
          end else if (BYTE_READY || timeout_hit) begin
            state_q   <= S_PKT_B1;
            timeout_q <= '0;
          end
        end
        S_PKT_B3: begin
          if (rx_ok) begin
            // Publish the packet on entry to IRQ so data and pulse appear together.
            status_q  <= sh_status_q;
            dx_q      <= sh_dx_q;
            dy_q      <= BYTE_READ;
            irq_q     <= 1'b1;
            state_q   <= S_IRQ;
            timeout_q <= '0;
          end else if (BYTE_READY || timeout_hit) begin
            state_q   <= S_PKT_B1;
            timeout_q <= '0;
          end
        end
        S_IRQ: begin
          state_q   <= S_PKT_B1;
          timeout_q <= '0;
        end
        default: begin
          state_q       <= S_INIT;
          read_enable_q <= 1'b0;
          init_done_q   <= 1'b0;
          timeout_q     <= '0;
        end
      endcase
    end
  end

  assign SEND_BYTE      = send_byte_q;
  assign BYTE_TO_SEND   = byte_to_send_q;
  assign READ_ENABLE    = read_enable_q;
  assign MOUSE_STATUS   = status_q;
  assign MOUSE_DX       = dx_q;
  assign MOUSE_DY       = dy_q;
  assign SEND_INTERRUPT = irq_q;
  assign INIT_DONE      = init_done_q;
  assign STATE_DBG      = state_q;

endmodule

// File: doc/mouse_master_sm.md
Name: mouse_master_sm

Overview:
PS/2 mouse master controller that sequences the transmitter and receiver inside the mouse transceiver. It issues the reset and enable-streaming command sequence and checks every mouse response. After initialisation it assembles 3-byte stream packets into status/dX/dY registers and pulses an interrupt so the transceiver can update its position counters. Runs on the 50 MHz system clock.

Parameters:
TIMEOUT_CYCLES, 5000000, cycles to wait for any expected event before aborting (100 ms at 50 MHz).
STARTUP_CYCLES, 500000, power-up delay in INIT before sending the first command (10 ms).

Ports:
CLK  in  1  system clock, 50 MHz
RESET  in  1  asynchronous, active-high reset
SEND_BYTE  out  1  one-cycle request to the transmitter
BYTE_TO_SEND  out  8  command byte; held stable from SEND_BYTE until BYTE_SENT
BYTE_SENT  in  1  one-cycle pulse from the transmitter: byte sent and acknowledged by the mouse
READ_ENABLE  out  1  receiver enable; high in every state except INIT, SEND_* and WAIT_SENT_*
BYTE_READ  in  8  received byte
BYTE_ERROR_CODE  in  2  receiver error code, 0 = OK
BYTE_READY  in  1  one-cycle pulse: BYTE_READ and BYTE_ERROR_CODE valid
MOUSE_STATUS  out  8  last accepted packet byte 1
MOUSE_DX  out  8  last accepted packet byte 2
MOUSE_DY  out  8  last accepted packet byte 3
SEND_INTERRUPT  out  1  one-cycle pulse when a new packet is available
INIT_DONE  out  1  high while streaming
STATE_DBG  out  4  current state code

Behaviour:
- Reset (async, RESET=1): state INIT, all outputs 0, BYTE_TO_SEND=0x00, all counters 0. Applies the same way mid-command or mid-packet.
- States and codes:
  - INIT 0: count STARTUP_CYCLES, then go to SEND_FF.
  - SEND_FF 1: SEND_BYTE=1 for exactly one cycle, BYTE_TO_SEND=0xFF, then go to WAIT_SENT_FF.
  - WAIT_SENT_FF 2: wait for BYTE_SENT.
  - WAIT_FA1 3: wait for 0xFA.
  - WAIT_AA 4: wait for 0xAA (self-test passed).
  - WAIT_ID 5: wait for 0x00 (device ID).
  - SEND_F4 6: SEND_BYTE=1 for one cycle, BYTE_TO_SEND=0xF4, then go to WAIT_SENT_F4.
  - WAIT_SENT_F4 7: wait for BYTE_SENT.
  - WAIT_FA2 8: wait for 0xFA.
  - PKT_B1 9, PKT_B2 10, PKT_B3 11: collect packet bytes.
  - IRQ 12: deliver the packet.
- A WAIT_* state advances on the cycle after BYTE_READY with BYTE_ERROR_CODE=0 and BYTE_READ equal to the expected value.
- In any init WAIT state, go to INIT (full retry, new startup delay) on any of:
  - BYTE_READY with BYTE_ERROR_CODE≠0;
  - BYTE_READY with a mismatched byte;
  - timeout.
- Timeout counter: cleared on every state change; timeout fires when the count reaches TIMEOUT_CYCLES-1 in the same state.
- INIT_DONE: set on entering PKT_B1 from WAIT_FA2. Cleared by reset or on any return to INIT.
- Stream capture:
  - PKT_B1 waits indefinitely, with no timeout. It accepts a byte only if error=0 and BYTE_READ[3]=1; otherwise the byte is dropped and the state stays PKT_B1 (resync).
  - PKT_B2 and PKT_B3 capture bytes with error=0. On an error code or a timeout, the partial packet is discarded and the state returns to PKT_B1. INIT_DONE stays 1.
  - Captured bytes go to internal shadow registers; the outputs do not change during collection.
- IRQ: one cycle. It copies the shadow registers to MOUSE_STATUS/DX/DY and pulses SEND_INTERRUPT=1 in the same cycle, so the outputs are valid with the pulse. Then go to PKT_B1.
- Latency: a valid byte-3 BYTE_READY at cycle n gives IRQ at n+1 and SEND_INTERRUPT/outputs visible at n+1. Successive packets need at least one idle cycle (IRQ).
- BYTE_READY arriving in a SEND_* or WAIT_SENT_* state is ignored. BYTE_SENT arriving outside WAIT_SENT_* is ignored.
- BYTE_READY and a timeout in the same cycle: BYTE_READY takes priority.
- Outputs are registered; STATE_DBG reflects the registered state.

Test Plan:
1. Init, with TIMEOUT_CYCLES=1000 and STARTUP_CYCLES=10: after the startup delay, SEND_BYTE pulses with 0xFF. Then drive BYTE_SENT and bytes FA, AA, 00. SEND_BYTE pulses again with 0xF4. Then BYTE_SENT and FA → INIT_DONE=1, STATE_DBG=9.
2. Packet: bytes 0x09, 0x1E, 0x2D → one SEND_INTERRUPT pulse with MOUSE_STATUS=0x09, MOUSE_DX=0x1E, MOUSE_DY=0x2D. The outputs hold those values until the next packet.
3. Resync: send byte 0x01 (bit3=0) → no state change. Then 0x08, 0x05, 0xFB → interrupt with DX=0x05, DY=0xFB.
4. Init faults: self-test byte 0xFC in WAIT_AA → INIT, and 0xFF is re-sent after the startup delay. No byte in WAIT_FA1 for 1000 cycles → INIT.
5. Stream faults: BYTE_ERROR_CODE=2 on byte 2 → no interrupt, state 9, previous outputs unchanged. Timeout in PKT_B3 → state 9, INIT_DONE still 1.
6. Reset mid-operation: assert RESET asynchronously mid-packet (between clock edges) → all outputs 0 immediately, state 0. Deassert RESET and the full init sequence repeats.
